// File: rtl/replay_buffer_pkg.sv
// Shared constants and types for the transmit-side replay buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package replay_buffer_pkg;

    localparam int DEPTH  = 4;                  // TLP entries held (power of 2)
    localparam int DATA_W = 128;                // TLP width
    localparam int OUT_W  = 16;                 // transmit word width
    localparam int WORDS  = DATA_W / OUT_W;     // words per TLP
    localparam int SEQ_W  = 12;                 // sequence-number width

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WSEL_W = $clog2(WORDS);
    // One extra bit so the word index can reach WORDS, which marks end of stream.
    localparam int IDX_W  = WSEL_W + 1;

    localparam logic [1:0] ACK = 2'b01;
    localparam logic [1:0] NAK = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        XMIT,
        PURGE,
        REPLAY
    } state_t;

endpackage

// File: rtl/rb_store.sv
// Replay storage: circular array of {TLP, seq} with head/tail/count and purge compare.
// Latency: write lands on the clock edge; read port and purge result are combinational.
// Backpressure: none internally; caller must not write when full.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr_en/wr_dat/wr_seq   append an entry at tail
//   purge_en/purge_seq    retire the oldest run of entries covered by purge_seq
//   rd_ptr/rd_dat         random read of stored TLP data
//   head, tail, count     occupancy state; full/empty flags
//   keep_head, keep_cnt   head and count that a purge this cycle would leave
module rb_store #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 128,
    parameter int SEQ_W  = 12,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [SEQ_W-1:0]  wr_seq,
    input  logic              purge_en,
    input  logic [SEQ_W-1:0]  purge_seq,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_dat,
    output logic [PTR_W-1:0]  head,
    output logic [PTR_W-1:0]  tail,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [PTR_W-1:0]  keep_head,
    output logic [CNT_W-1:0]  keep_cnt
);

    logic [DATA_W-1:0] dat_mem [DEPTH];
    logic [SEQ_W-1:0]  seq_mem [DEPTH];

    logic [CNT_W-1:0]  drop;
    logic              run;
    logic [PTR_W-1:0]  scan_ptr;
    logic [SEQ_W-1:0]  seq_diff;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign rd_dat = dat_mem[rd_ptr];

    // Walk from the oldest entry; an entry is covered when it lies at or before
    // purge_seq in the half-range modular window, i.e. the MSB of
    // (purge_seq - entry_seq) is clear. The first uncovered entry ends the run.
    always_comb begin
        drop     = '0;
        run      = 1'b1;
        scan_ptr = '0;
        seq_diff = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_ptr = head + PTR_W'(i);
            seq_diff = purge_seq - seq_mem[scan_ptr];
            if (run && (CNT_W'(i) < count) && !seq_diff[SEQ_W-1]) begin
                drop = drop + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign keep_head = head + drop[PTR_W-1:0];
    assign keep_cnt  = count - drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (wr_en) begin
            tail  <= tail + PTR_W'(1);
            count <= count + CNT_W'(1);
        end else if (purge_en) begin
            head  <= keep_head;
            count <= keep_cnt;
        end
    end

    // Payload array carries no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            dat_mem[tail] <= wr_dat;
            seq_mem[tail] <= wr_seq;
        end
    end

endmodule

// File: rtl/replay_buffer.sv
// Transmit replay buffer: stores sequenced TLPs, streams them as 16-bit words, retires on ACK, replays on NAK/timeout.
// Latency: first word on the accept edge, last word 7 edges later, dout back to 0 on the following edge.
// Backpressure: busy_n=0 freezes the stream; ready=0 outside IDLE or when full (we ignored then).
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   busy_n         0 holds dout and the word/entry position
//   ack_nack, seq  DLLP acknowledge (01 ACK, 10 NAK) and its sequence number
//   tim_out        replay-timer expiry pulse
//   ready          IDLE and not full
//   we, din        new TLP write
//   dout           word stream, 0 when idle
module replay_buffer
    import replay_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              busy_n,
    input  logic [1:0]        ack_nack,
    input  logic [SEQ_W-1:0]  seq,
    input  logic              tim_out,
    output logic              ready,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [OUT_W-1:0]  dout
);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [PTR_W-1:0]   xmit_ptr, xmit_ptr_nx;   // entry being sent fresh
    logic [PTR_W-1:0]   rply_ptr, rply_ptr_nx;   // entry being replayed
    logic [CNT_W-1:0]   rply_cnt, rply_cnt_nx;   // entries left to replay, including current
    logic               purge_nak, purge_nak_nx;
    logic [SEQ_W-1:0]   purge_seq, purge_seq_nx;
    logic [SEQ_W-1:0]   next_seq, next_seq_nx;
    logic [OUT_W-1:0]   dout_nx;

    logic               wr_en;
    logic               purge_en;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  rd_dat;
    logic [PTR_W-1:0]   st_head;
    logic [PTR_W-1:0]   st_tail;
    logic [CNT_W-1:0]   st_count;
    logic               st_full;
    logic               st_empty;
    logic [PTR_W-1:0]   keep_head;
    logic [CNT_W-1:0]   keep_cnt;

    logic [WSEL_W-1:0]  word_sel;
    logic [OUT_W-1:0]   cur_word;

    rb_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .SEQ_W  (SEQ_W),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_dat    (din),
        .wr_seq    (next_seq),
        .purge_en  (purge_en),
        .purge_seq (purge_seq),
        .rd_ptr    (rd_ptr),
        .rd_dat    (rd_dat),
        .head      (st_head),
        .tail      (st_tail),
        .count     (st_count),
        .full      (st_full),
        .empty     (st_empty),
        .keep_head (keep_head),
        .keep_cnt  (keep_cnt)
    );

    assign ready  = (state == IDLE) && !st_full;
    assign rd_ptr = (state == XMIT) ? xmit_ptr : rply_ptr;

    // Word mux, most-significant word first.
    assign word_sel = idx[WSEL_W-1:0];
    always_comb begin
        cur_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_sel == WSEL_W'(w)) begin
                cur_word = rd_dat[DATA_W-1-w*OUT_W -: OUT_W];
            end
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        xmit_ptr_nx  = xmit_ptr;
        rply_ptr_nx  = rply_ptr;
        rply_cnt_nx  = rply_cnt;
        purge_nak_nx = purge_nak;
        purge_seq_nx = purge_seq;
        next_seq_nx  = next_seq;
        dout_nx      = dout;
        wr_en        = 1'b0;
        purge_en     = 1'b0;

        case (state)
            IDLE: begin
                if (ack_nack == NAK) begin
                    purge_nak_nx = 1'b1;
                    purge_seq_nx = seq;
                    state_nx     = PURGE;
                end else if (tim_out) begin
                    if (!st_empty) begin
                        rply_ptr_nx = st_head;
                        rply_cnt_nx = st_count;
                        idx_nx      = '0;
                        state_nx    = REPLAY;
                    end
                end else if (ack_nack == ACK) begin
                    purge_nak_nx = 1'b0;
                    purge_seq_nx = seq;
                    state_nx     = PURGE;
                end else if (we && !st_full) begin
                    wr_en       = 1'b1;
                    xmit_ptr_nx = st_tail;
                    next_seq_nx = next_seq + SEQ_W'(1);
                    // Word 0 comes straight from din: the array write lands on this same edge.
                    dout_nx     = din[DATA_W-1 -: OUT_W];
                    idx_nx      = IDX_W'(1);
                    state_nx    = XMIT;
                end
            end

            XMIT: begin
                if (busy_n) begin
                    if (idx == IDX_W'(WORDS)) begin
                        dout_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        dout_nx = cur_word;
                        idx_nx  = idx + IDX_W'(1);
                    end
                end
            end

            PURGE: begin
                purge_en = 1'b1;
                if (purge_nak && (keep_cnt != '0)) begin
                    rply_ptr_nx = keep_head;
                    rply_cnt_nx = keep_cnt;
                    idx_nx      = '0;
                    state_nx    = REPLAY;
                end else begin
                    state_nx = IDLE;
                end
            end

            REPLAY: begin
                if (busy_n) begin
                    if (rply_cnt == '0) begin
                        dout_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        dout_nx = cur_word;
                        if (idx == IDX_W'(WORDS - 1)) begin
                            idx_nx      = '0;
                            rply_ptr_nx = rply_ptr + PTR_W'(1);
                            rply_cnt_nx = rply_cnt - CNT_W'(1);
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            xmit_ptr  <= '0;
            rply_ptr  <= '0;
            rply_cnt  <= '0;
            purge_nak <= 1'b0;
            purge_seq <= '0;
            next_seq  <= '0;
            dout      <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            xmit_ptr  <= xmit_ptr_nx;
            rply_ptr  <= rply_ptr_nx;
            rply_cnt  <= rply_cnt_nx;
            purge_nak <= purge_nak_nx;
            purge_seq <= purge_seq_nx;
            next_seq  <= next_seq_nx;
            dout      <= dout_nx;
        end
    end

endmodule

// File: tb/tb_replay_buffer.sv
// Self-checking bench for replay_buffer against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: busy_n driven directed or random per test.
`timescale 1ns/1ps
module tb_replay_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         busy_n;
    logic [1:0]   ack_nack;
    logic [11:0]  seq;
    logic         tim_out;
    logic         ready;
    logic         we;
    logic [127:0] din;
    logic [15:0]  dout;

    always #5 clk = ~clk;

    replay_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .busy_n   (busy_n),
        .ack_nack (ack_nack),
        .seq      (seq),
        .tim_out  (tim_out),
        .ready    (ready),
        .we       (we),
        .din      (din),
        .dout     (dout)
    );

    // Reference model: outstanding TLPs oldest first, plus next sequence number.
    typedef struct packed {
        logic [127:0] dat;
        logic [11:0]  sq;
    } ent_t;

    ent_t q[$];
    int   next_seq;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [127:0] d, input int i);
        logic [127:0] s;
        s = d >> (112 - 16 * i);
        return s[15:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Clock edge, then release the one-shot request inputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        we       = 1'b0;
        ack_nack = 2'b00;
        tim_out  = 1'b0;
    endtask

    // Called right after the triggering edge. dout must show `first` now, then
    // hold 0 for `lead` edges regardless of busy_n, then advance one word per
    // edge with busy_n=1 through wl_in and finally back to 0.
    // bmode: 0 never busy, 1 random busy, 2 three busy cycles while word 3 is shown.
    task automatic follow(input logic [15:0] first, input int lead,
                          input logic [15:0] wl_in[$], input int bmode);
        logic [15:0] wl[$];
        logic [15:0] exp;
        int pos;
        int stalls;
        wl = wl_in;
        wl.push_back(16'h0000);
        exp = first;
        check_val("dout_first", 32'(dout), 32'(exp));
        check_val("ready_busy", 32'(ready), 32'd0);
        for (int l = 0; l < lead; l++) begin
            @(negedge clk);
            busy_n = 1'($urandom_range(0, 1));
            tick();
            check_val("dout_lead", 32'(dout), 32'd0);
        end
        pos = 0;
        stalls = 0;
        while (pos < wl.size()) begin
            @(negedge clk);
            busy_n = 1'b1;
            if (bmode == 1) busy_n = ($urandom_range(0, 7) != 0);
            if (bmode == 2 && pos == 3 && stalls < 3) begin
                busy_n = 1'b0;
                stalls++;
            end
            tick();
            if (busy_n) begin
                exp = wl[pos];
                pos++;
            end
            check_val("dout", 32'(dout), 32'(exp));
        end
        @(negedge clk);
        busy_n = 1'b1;
        check_val("ready_end", 32'(ready), 32'(q.size() < 4));
    endtask

    task automatic do_write(input logic [127:0] d, input int bmode);
        logic [15:0] wl[$];
        @(negedge clk);
        check_val("ready_pre", 32'(ready), 32'(q.size() < 4));
        we  = 1'b1;
        din = d;
        tick();
        if (q.size() < 4) begin
            q.push_back('{dat: d, sq: 12'(next_seq)});
            next_seq = (next_seq + 1) % 4096;
            for (int i = 1; i < 8; i++) wl.push_back(word_of(d, i));
            follow(word_of(d, 0), 0, wl, bmode);
        end else begin
            check_val("dout_full_we", 32'(dout), 32'd0);
            check_val("ready_full", 32'(ready), 32'd0);
        end
    endtask

    function automatic void model_purge(input int s);
        while (q.size() > 0 && (((s - int'(q[0].sq)) & 4095) < 2048)) void'(q.pop_front());
    endfunction

    task automatic replay_words(output logic [15:0] wl[$]);
        wl.delete();
        foreach (q[e]) for (int i = 0; i < 8; i++) wl.push_back(word_of(q[e].dat, i));
    endtask

    task automatic do_ack(input int s, input bit nak, input int bmode);
        logic [15:0] wl[$];
        @(negedge clk);
        ack_nack = nak ? 2'b10 : 2'b01;
        seq      = 12'(s);
        tick();
        model_purge(s);
        if (nak && q.size() > 0) begin
            replay_words(wl);
            follow(16'h0000, 1, wl, bmode);
        end else begin
            check_val("dout_purge", 32'(dout), 32'd0);
            check_val("ready_purge", 32'(ready), 32'd0);
            @(negedge clk);
            tick();
            check_val("dout_after_ack", 32'(dout), 32'd0);
            check_val("ready_after_ack", 32'(ready), 32'(q.size() < 4));
        end
    endtask

    task automatic do_timeout(input int bmode);
        logic [15:0] wl[$];
        @(negedge clk);
        tim_out = 1'b1;
        tick();
        if (q.size() > 0) begin
            replay_words(wl);
            follow(16'h0000, 0, wl, bmode);
        end else begin
            for (int k = 0; k < 3; k++) begin
                check_val("dout_tmo_empty", 32'(dout), 32'd0);
                check_val("ready_tmo_empty", 32'(ready), 32'd1);
                @(negedge clk);
                tick();
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("dout_reset", 32'(dout), 32'd0);
        check_val("ready_reset", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        next_seq = 0;
    endtask

    task automatic random_ops(input int n);
        int r;
        int base;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            base = (q.size() > 0) ? int'(q[0].sq) : next_seq;
            if (r <= 4) do_write(rand128(), 1);
            else if (r <= 6) do_ack((base + $urandom_range(0, 6) - 2) & 4095, 1'b0, 1);
            else if (r == 7) do_ack((base + $urandom_range(0, 4) - 2) & 4095, 1'b1, 1);
            else if (r == 8) do_timeout(1);
            else begin
                @(negedge clk);
                tick();
                check_val("dout_idle", 32'(dout), 32'd0);
                check_val("ready_idle", 32'(ready), 32'(q.size() < 4));
            end
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        busy_n   = 1'b1;
        ack_nack = 2'b00;
        seq      = '0;
        tim_out  = 1'b0;
        we       = 1'b0;
        din      = '0;
        next_seq = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("dout_reset", 32'(dout), 32'd0);
        check_val("ready_reset", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single TLP streamed, then a TLP with a 3-cycle stall on word 3.
        do_write(128'h400000010000000ffdaff04012345678, 0);
        do_write(rand128(), 2);

        // Fill to 4 entries, 5th write ignored, ACK 1 retires seq 0 and 1.
        do_write(rand128(), 0);
        do_write(rand128(), 0);
        do_write(rand128(), 0);
        do_ack(1, 1'b0, 0);

        // NAK 2: seq 2 purged, seq 3 replayed.
        do_ack(2, 1'b1, 0);

        // Timeout with two entries replays both; empty timeout does nothing.
        do_write(rand128(), 0);
        do_timeout(1);
        do_ack(4, 1'b0, 0);
        do_timeout(0);
        // NAK and ACK on an empty buffer.
        do_ack(7, 1'b1, 0);
        do_ack(7, 1'b0, 0);

        // Reset in the middle of a transmit stream.
        @(negedge clk);
        we  = 1'b1;
        din = rand128();
        tick();
        repeat (3) begin
            @(negedge clk);
            tick();
        end
        #1;
        reset = 1'b1;
        #1;
        check_val("dout_mid_reset", 32'(dout), 32'd0);
        check_val("ready_mid_reset", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        next_seq = 0;

        random_ops(300);

        // Advance the sequence counter to 4095, retiring along the way.
        do_reset();
        for (int i = 0; i < 4095; i++) begin
            do_write(rand128(), 0);
            if (q.size() == 4) do_ack((next_seq + 4095) & 4095, 1'b0, 0);
        end
        do_ack(4094, 1'b0, 0);
        // Entries 4095 and 0: an ACK older than both purges nothing, ACK 0 purges both.
        do_write(rand128(), 0);
        do_write(rand128(), 1);
        do_ack(4094, 1'b0, 0);
        do_timeout(0);
        do_ack(0, 1'b0, 0);
        do_timeout(0);

        random_ops(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
